// File: rtl/pixel_writer_pkg.sv
// Shared types and defaults for the pixel frame writer: FSM state encoding
// and the default frame length in FIFO words.
package pixel_writer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    PUSH       = 2'd2,
    ACK        = 2'd3
  } pw_state_t;

  // 23 strings x 236 LEDs x 24 bit / 16 bit words
  localparam int FRAME_WORDS_DEFAULT = 8142;

endpackage

// File: rtl/pixel_frame_writer_space_timeout.sv
// space_timeout: counts cycles spent waiting for FIFO space and flags the
// last permitted wait cycle so the writer can drop the pending word.
module space_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable && (wait_cnt != LAST_CNT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // High during the TIMEOUT_CYCLES-th consecutive wait cycle.
  assign expired = enable && (wait_cnt == LAST_CNT);

endmodule

// File: rtl/pixel_frame_writer.sv
// Bridges single-word regmap writes into the pixel FIFO with flow control,
// timeout-based dropping and frame position tracking.
// Optional statistics outputs enabled by defining PIXEL_FRAME_WRITER_STATS_EN.
module pixel_frame_writer
  import pixel_writer_pkg::*;
#(
  parameter int FIFO_ADDR_WIDTH = 13,
  parameter int FIFO_DATA_WIDTH = 16,
  parameter int FRAME_WORDS     = FRAME_WORDS_DEFAULT,
  parameter int SPACE_MARGIN    = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_req,
  input  logic [FIFO_DATA_WIDTH-1:0] wr_data,
  output logic                       wr_ack,
  input  logic                       frame_sync,
  input  logic [FIFO_ADDR_WIDTH:0]   fifo_empty_count,
  output logic                       fifo_wr,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  output logic                       frame_done,
  output logic [FIFO_ADDR_WIDTH:0]   word_index,
  output logic                       drop_event,
  output logic                       protocol_err
`ifdef PIXEL_FRAME_WRITER_STATS_EN
  ,
  output logic [15:0]                frame_count,
  output logic [15:0]                drop_count
`endif
);

  localparam int CW = FIFO_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MARGIN    = CW'(SPACE_MARGIN);
  localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] ONE_WORD  = CW'(1);

  pw_state_t state, state_n;
  logic      space_ok;
  logic      push_go;
  logic      drop_go;
  logic      word_evt;
  logic      frame_end;
  logic      tmo_clear;
  logic      tmo_expired;

  assign space_ok  = (fifo_empty_count > MARGIN);
  assign word_evt  = push_go || drop_go;
  // A word event is committed on the edge that raises fifo_wr/drop_event;
  // a frame_sync sampled on that same edge makes the word position 0.
  assign frame_end = word_evt && !frame_sync && (word_index == LAST_WORD);

  space_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_space_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tmo_clear),
    .enable (state == WAIT_SPACE),
    .expired(tmo_expired)
  );

  always_comb begin
    state_n   = state;
    push_go   = 1'b0;
    drop_go   = 1'b0;
    tmo_clear = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          tmo_clear = 1'b1;
          if (space_ok) begin
            state_n = PUSH;
            push_go = 1'b1;
          end else begin
            state_n = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          state_n = PUSH;
          push_go = 1'b1;
        end else if (tmo_expired) begin
          state_n = ACK;
          drop_go = 1'b1;
        end
      end
      PUSH:    state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fifo_wr      <= 1'b0;
      fifo_data    <= '0;
      wr_ack       <= 1'b0;
      drop_event   <= 1'b0;
      protocol_err <= 1'b0;
      frame_done   <= 1'b0;
      word_index   <= '0;
    end else begin
      state        <= state_n;
      fifo_wr      <= push_go;
      wr_ack       <= (state_n == ACK);
      drop_event   <= drop_go;
      protocol_err <= wr_req && (state != IDLE);
      frame_done   <= frame_end;
      if ((state == IDLE) && wr_req) begin
        fifo_data <= wr_data;
      end
      if (frame_sync) begin
        word_index <= word_evt ? ONE_WORD : '0;
      end else if (word_evt) begin
        word_index <= (word_index == LAST_WORD) ? '0 : word_index + 1'b1;
      end
    end
  end

`ifdef PIXEL_FRAME_WRITER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (frame_end) begin
        frame_count <= frame_count + 1'b1;
      end
      if (drop_go && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer (FRAME_WORDS=4, TIMEOUT_CYCLES=16).
module tb_pixel_frame_writer;

  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          frame_sync;
  logic [AW:0]   fifo_empty_count;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data;
  logic          frame_done;
  logic [AW:0]   word_index;
  logic          drop_event;
  logic          protocol_err;

  int checks = 0;
  int errors = 0;
  int pulses;

  pixel_frame_writer #(
    .FIFO_ADDR_WIDTH(AW),
    .FIFO_DATA_WIDTH(DW),
    .FRAME_WORDS    (4),
    .SPACE_MARGIN   (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_req          (wr_req),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .frame_sync      (frame_sync),
    .fifo_empty_count(fifo_empty_count),
    .fifo_wr         (fifo_wr),
    .fifo_data       (fifo_data),
    .frame_done      (frame_done),
    .word_index      (word_index),
    .drop_event      (drop_event),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    wr_req           = 1'b0;
    wr_data          = '0;
    frame_sync       = 1'b0;
    fifo_empty_count = 14'd8192;
    tick();
    tick();
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_fifo_data", 32'(fifo_data), 32'd0);
    chk("rst_word_index", 32'(word_index), 32'd0);
    chk("rst_pulses", {29'd0, drop_event, protocol_err, frame_done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single write with ample space
    wr_req  = 1'b1;
    wr_data = 16'h1234;
    tick();
    wr_req = 1'b0;
    chk("t1_fifo_wr", 32'(fifo_wr), 32'd1);
    chk("t1_fifo_data", 32'(fifo_data), 32'h1234);
    chk("t1_ack_early", 32'(wr_ack), 32'd0);
    chk("t1_word_index", 32'(word_index), 32'd1);
    tick();
    chk("t1_fifo_wr_once", 32'(fifo_wr), 32'd0);
    chk("t1_wr_ack", 32'(wr_ack), 32'd1);
    tick();
    chk("t1_wr_ack_once", 32'(wr_ack), 32'd0);

    // Low space for 10 cycles, then space appears
    fifo_empty_count = 14'd2;
    wr_req  = 1'b1;
    wr_data = 16'hABCD;
    tick();
    wr_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(fifo_wr) + int'(wr_ack) + int'(drop_event);
    end
    chk("t2_no_wr_while_full", 32'(pulses), 32'd0);
    fifo_empty_count = 14'd100;
    tick();
    chk("t2_fifo_wr", 32'(fifo_wr), 32'd1);
    chk("t2_fifo_data", 32'(fifo_data), 32'hABCD);
    chk("t2_word_index", 32'(word_index), 32'd2);
    tick();
    chk("t2_wr_ack", 32'(wr_ack), 32'd1);
    tick();

    // Empty count 0 held: drop after 16 wait cycles
    fifo_empty_count = 14'd0;
    wr_req  = 1'b1;
    wr_data = 16'h5555;
    tick();
    wr_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      pulses += int'(fifo_wr) + int'(wr_ack) + int'(drop_event);
    end
    chk("t3_quiet_15", 32'(pulses), 32'd0);
    tick();
    chk("t3_drop_event", 32'(drop_event), 32'd1);
    chk("t3_wr_ack", 32'(wr_ack), 32'd1);
    chk("t3_no_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("t3_word_index", 32'(word_index), 32'd3);
    tick();
    chk("t3_drop_once", 32'(drop_event), 32'd0);

    // Resync, then 9 writes across two frames of 4 words
    fifo_empty_count = 14'd100;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("t4_sync_clear", 32'(word_index), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      wr_req  = 1'b1;
      wr_data = 16'(i);
      tick();
      wr_req = 1'b0;
      chk($sformatf("t4_fifo_wr_%0d", i), 32'(fifo_wr), 32'd1);
      chk($sformatf("t4_frame_done_%0d", i), 32'(frame_done), (i == 4 || i == 8) ? 32'd1 : 32'd0);
      tick();
      tick();
    end
    chk("t4_word_index_end", 32'(word_index), 32'd1);

    // frame_sync together with the 3rd push: that push becomes word 0
    for (int i = 1; i <= 3; i++) begin
      wr_req     = 1'b1;
      wr_data    = 16'(16'hC000 + i);
      frame_sync = (i == 3);
      tick();
      wr_req     = 1'b0;
      frame_sync = 1'b0;
      if (i == 3) begin
        chk("t5_sync_fifo_wr", 32'(fifo_wr), 32'd1);
        chk("t5_sync_word_index", 32'(word_index), 32'd1);
        chk("t5_sync_no_frame_done", 32'(frame_done), 32'd0);
      end
      tick();
      tick();
    end

    // Second wr_req while waiting for space
    fifo_empty_count = 14'd0;
    wr_req  = 1'b1;
    wr_data = 16'h7777;
    tick();
    chk("t5_first_req_no_err", 32'(protocol_err), 32'd0);
    wr_data = 16'h8888;
    tick();
    wr_req = 1'b0;
    chk("t5_protocol_err", 32'(protocol_err), 32'd1);
    tick();
    chk("t5_protocol_err_once", 32'(protocol_err), 32'd0);
    fifo_empty_count = 14'd100;
    pulses = 0;
    tick();
    chk("t5_fifo_data_kept", 32'(fifo_data), 32'h7777);
    pulses += int'(fifo_wr);
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(fifo_wr);
    end
    chk("t5_single_fifo_wr", 32'(pulses), 32'd1);
    chk("t5_word_index", 32'(word_index), 32'd2);

    // Reset while waiting for space
    fifo_empty_count = 14'd0;
    wr_req  = 1'b1;
    wr_data = 16'h9999;
    tick();
    wr_req = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_async_word_index", 32'(word_index), 32'd0);
    chk("t6_async_fifo_data", 32'(fifo_data), 32'd0);
    tick();
    reset_n = 1'b1;
    fifo_empty_count = 14'd100;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(fifo_wr) + int'(wr_ack) + int'(drop_event);
    end
    chk("t6_no_activity_after_reset", 32'(pulses), 32'd0);
    chk("t6_word_index", 32'(word_index), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
